// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the 11110 serial pattern detector
package seq_det_pkg;

  typedef enum logic [2:0] {
    S0    = 3'd0,
    S1    = 3'd1,
    S11   = 3'd2,
    S111  = 3'd3,
    S1111 = 3'd4,
    SDET  = 3'd5
  } seq_state_t;

  localparam logic [4:0] SEQ_PATTERN = 5'b11110;
  localparam int         CNT_W       = 8;

endpackage

// File: rtl/seq_match_counter.sv
// rtl/seq_match_counter.sv - saturating match counter, holds at all-ones instead of wrapping
module seq_match_counter
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detector.sv
// rtl/seq_detector.sv - Moore detector for serial pattern 1,1,1,1,0 with overlap
// Optional macro SEQ_DET_COUNT_EN adds the saturating det_cnt output.
module seq_detector
  import seq_det_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             serIn,
  output logic             w
`ifdef SEQ_DET_COUNT_EN
  ,
  output logic [CNT_W-1:0] det_cnt
`endif
);

  localparam logic MARK_BIT = SEQ_PATTERN[4];
  localparam logic END_BIT  = SEQ_PATTERN[0];

  seq_state_t state;
  seq_state_t state_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
      w     <= 1'b0;
    end else begin
      state <= state_next;
      // Registered copy of (state == SDET) so w never glitches on decode.
      w     <= (state_next == SDET);
    end
  end

  always_comb begin
    state_next = S0;
    case (state)
      S0:      state_next = (serIn == MARK_BIT) ? S1    : S0;
      S1:      state_next = (serIn == MARK_BIT) ? S11   : S0;
      S11:     state_next = (serIn == MARK_BIT) ? S111  : S0;
      S111:    state_next = (serIn == MARK_BIT) ? S1111 : S0;
      // Longer runs of ones still end in "1111", so stay put.
      S1111:   state_next = (serIn == END_BIT)  ? SDET  : S1111;
      SDET:    state_next = (serIn == MARK_BIT) ? S1    : S0;
      default: state_next = S0;
    endcase
  end

`ifdef SEQ_DET_COUNT_EN
  seq_match_counter u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (state_next == SDET),
    .cnt (det_cnt)
  );
`endif

endmodule

// File: tb/tb_seq_detector.sv
// tb/tb_seq_detector.sv - scoreboard bench for seq_detector against a sliding-window model
module tb_seq_detector;

  typedef struct {
    logic       w;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic serIn;
  logic w;
`ifdef SEQ_DET_COUNT_EN
  logic [7:0] det_cnt;
`endif

  int tests = 0;
  int fails = 0;

  exp_t       exp_q[$];
  logic [4:0] hist;
  int         mdl_cnt;

  seq_detector dut (
    .clk   (clk),
    .rst   (rst),
    .serIn (serIn),
    .w     (w)
`ifdef SEQ_DET_COUNT_EN
    ,
    .det_cnt (det_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a match is simply the last five sampled bits equalling 11110.
  task automatic drive(input logic b);
    exp_t e;
    serIn = b;
    hist  = {hist[3:0], b};
    e.w   = (hist == 5'b11110);
    if (e.w && mdl_cnt < 255) mdl_cnt++;
    e.cnt = 8'(mdl_cnt);
    exp_q.push_back(e);
  endtask

  task automatic apply_bit(input logic b);
    @(negedge clk);
    drive(b);
  endtask

  task automatic apply_seq(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) apply_bit(bits[i]);
  endtask

  // Reset lands between edges; releasing it also drives the next sampled bit.
  task automatic async_reset(input string name);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check({name, "_w"}, 32'(w), 32'd0);
`ifdef SEQ_DET_COUNT_EN
    check({name, "_cnt"}, 32'(det_cnt), 32'd0);
`endif
    hist    = '0;
    mdl_cnt = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("w", 32'(w), 32'(e.w));
`ifdef SEQ_DET_COUNT_EN
      check("det_cnt", 32'(det_cnt), 32'(e.cnt));
`endif
    end
  end

  initial begin
    rst     = 1'b1;
    serIn   = 1'b0;
    hist    = '0;
    mdl_cnt = 0;
    repeat (2) @(negedge clk);
    check("reset_w", 32'(w), 32'd0);
`ifdef SEQ_DET_COUNT_EN
    check("reset_cnt", 32'(det_cnt), 32'd0);
`endif
    rst = 1'b0;
    drive(1'b0);

    apply_seq(32'b0011_1110, 8);
    apply_bit(1'b0);
    apply_seq(32'b111_0110, 7);
    apply_seq(32'b11110_11110, 10);
    apply_seq(32'b1111_1111_0, 9);

    // Reset while w is high, then reset after a partial 1111 prefix.
    apply_seq(32'b11110, 5);
    async_reset("rst_during_pulse");
    apply_seq(32'b1111, 4);
    async_reset("rst_mid_seq");
    apply_bit(1'b0);
    apply_seq(32'b11110, 5);

    for (int i = 0; i < 2000; i++) apply_bit($urandom_range(0, 3) != 0);

    for (int i = 0; i < 300; i++) apply_seq(32'b11110, 5);
    apply_seq(32'b1111_0, 5);
    apply_bit(1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
`ifdef SEQ_DET_COUNT_EN
    check("cnt_saturated", 32'(det_cnt), 32'd255);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
